// File: rtl/regfile_sb.sv
// General-purpose register file: two registered operand ports (ra/rb), one
// combinational store-data port (rt), write/link bypass and a busy scoreboard.
module regfile_sb #(
  parameter int DataSize  = 32,
  parameter int AddrSize  = 5,
  parameter int LinkReg   = 30,
  parameter int PcSize    = 10,
  parameter int ZeroRegEn = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_reg_fetch,
  input  logic [AddrSize-1:0] reg_ra_addr,
  input  logic [AddrSize-1:0] reg_rb_addr,
  input  logic [AddrSize-1:0] reg_rt_addr,
  input  logic                enable_reg_write,
  input  logic                do_reg_write,
  input  logic [AddrSize-1:0] write_reg_addr,
  input  logic [DataSize-1:0] write_reg_data,
  input  logic                do_link,
  input  logic [PcSize-1:0]   current_pc,
  input  logic                issue_valid,
  input  logic [AddrSize-1:0] issue_dest_addr,
  output logic [DataSize-1:0] reg_ra_data,
  output logic [DataSize-1:0] reg_rb_data,
  output logic [DataSize-1:0] reg_rt_data,
  output logic                fetch_stall
);

  localparam int NumRegs = 2 ** AddrSize;
  localparam logic [AddrSize-1:0] LinkAddr = AddrSize'(LinkReg);

  logic                wb_en;
  logic [DataSize-1:0] link_value;

  logic [DataSize-1:0] regs_reg  [NumRegs];
  logic [DataSize-1:0] regs_next [NumRegs];
  logic [NumRegs-1:0]  busy_reg;
  logic [NumRegs-1:0]  busy_next;

  assign wb_en      = enable_reg_write & do_reg_write;
  assign link_value = DataSize'(current_pc);

  // Per-register next state: link beats writeback; a new issue beats a clear.
  generate
    for (genvar gi = 0; gi < NumRegs; gi++) begin : g_reg
      localparam logic [AddrSize-1:0] Idx = AddrSize'(gi);
      localparam bit IsZero = (ZeroRegEn != 0) && (gi == 0);

      logic link_hit;
      logic wb_hit;
      logic issue_hit;

      assign link_hit  = do_link && (LinkAddr == Idx) && !IsZero;
      assign wb_hit    = wb_en && (write_reg_addr == Idx) && !IsZero;
      assign issue_hit = issue_valid && (issue_dest_addr == Idx) && !IsZero;

      assign regs_next[gi] = link_hit ? link_value :
                             wb_hit   ? write_reg_data : regs_reg[gi];
      assign busy_next[gi] = issue_hit | (busy_reg[gi] & ~wb_hit);
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      regs_reg <= regs_next;
      busy_reg <= busy_next;
    end
  end

  // Read ports: 0 = ra, 1 = rb, 2 = rt.
  logic [AddrSize-1:0] port_addr [3];
  logic [DataSize-1:0] port_eff  [3];
  logic [2:0]          port_zero;
  logic [1:0]          port_pend;

  assign port_addr[0] = reg_ra_addr;
  assign port_addr[1] = reg_rb_addr;
  assign port_addr[2] = reg_rt_addr;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
      assign port_zero[gi] = (ZeroRegEn != 0) && (port_addr[gi] == '0);
      assign port_eff[gi]  =
          port_zero[gi]                                ? '0 :
          (do_link && (port_addr[gi] == LinkAddr))     ? link_value :
          (wb_en && (port_addr[gi] == write_reg_addr)) ? write_reg_data :
                                                         regs_reg[port_addr[gi]];
    end

    // A writeback landing this cycle resolves the hazard via the bypass.
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      assign port_pend[gi] = !port_zero[gi] && busy_reg[port_addr[gi]] &&
                             !(wb_en && (write_reg_addr == port_addr[gi]));
    end
  endgenerate

  assign fetch_stall = enable_reg_fetch & (|port_pend);
  assign reg_rt_data = port_eff[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_ra_data <= '0;
      reg_rb_data <= '0;
    end else if (enable_reg_fetch && !fetch_stall) begin
      reg_ra_data <= port_eff[0];
      reg_rb_data <= port_eff[1];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected values tagged with
// the cycle they must appear in; a negedge monitor pops and compares them.
module tb_regfile_sb;

  logic        clock;
  logic        reset;
  logic        enable_reg_fetch;
  logic [4:0]  reg_ra_addr;
  logic [4:0]  reg_rb_addr;
  logic [4:0]  reg_rt_addr;
  logic        enable_reg_write;
  logic        do_reg_write;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_reg_data;
  logic        do_link;
  logic [9:0]  current_pc;
  logic        issue_valid;
  logic [4:0]  issue_dest_addr;
  logic [31:0] reg_ra_data;
  logic [31:0] reg_rb_data;
  logic [31:0] reg_rt_data;
  logic        fetch_stall;

  regfile_sb dut (
    .clock            (clock),
    .reset            (reset),
    .enable_reg_fetch (enable_reg_fetch),
    .reg_ra_addr      (reg_ra_addr),
    .reg_rb_addr      (reg_rb_addr),
    .reg_rt_addr      (reg_rt_addr),
    .enable_reg_write (enable_reg_write),
    .do_reg_write     (do_reg_write),
    .write_reg_addr   (write_reg_addr),
    .write_reg_data   (write_reg_data),
    .do_link          (do_link),
    .current_pc       (current_pc),
    .issue_valid      (issue_valid),
    .issue_dest_addr  (issue_dest_addr),
    .reg_ra_data      (reg_ra_data),
    .reg_rb_data      (reg_rb_data),
    .reg_rt_data      (reg_rt_data),
    .fetch_stall      (fetch_stall)
  );

  typedef enum {K_RA, K_RB, K_RT, K_STALL} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   c = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // Monitor: combinational outputs reflect this cycle's inputs, registered
  // outputs reflect the previous edge.
  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] got;
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      case (e.kind)
        K_RA:    got = reg_ra_data;
        K_RB:    got = reg_rb_data;
        K_RT:    got = reg_rt_data;
        default: got = {31'd0, fetch_stall};
      endcase
      n_checks++;
      if (e.cyc < cyc_cnt)
        $display("FAIL %s: checked late at cycle %0d, wanted cycle %0d", e.name, cyc_cnt, e.cyc);
      else if (got !== e.val)
        $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc_cnt, got, e.val);
      else begin
        n_pass++;
        $display("ok   %s: cycle %0d value %h", e.name, cyc_cnt, got);
      end
    end
  end

  task automatic push(input int cy, input kind_t k, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cy; e.kind = k; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic idle();
    enable_reg_fetch = 0; reg_ra_addr = 0; reg_rb_addr = 0; reg_rt_addr = 0;
    enable_reg_write = 0; do_reg_write = 0; write_reg_addr = 0; write_reg_data = 0;
    do_link = 0; current_pc = 0; issue_valid = 0; issue_dest_addr = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
    c = cyc_cnt;
  endtask

  task automatic fetch(input logic [4:0] a, input logic [4:0] b);
    enable_reg_fetch = 1; reg_ra_addr = a; reg_rb_addr = b;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    enable_reg_write = 1; do_reg_write = 1; write_reg_addr = a; write_reg_data = d;
  endtask

  initial begin
    reset = 1;
    idle();
    step();
    push(c, K_RA, 32'h0, "reset_ra");
    push(c, K_RB, 32'h0, "reset_rb");
    push(c, K_STALL, 32'h0, "reset_stall");
    step();
    reset = 0;

    // Basic write/read and register 0 behaviour.
    step(); fetch(5, 0);
    push(c, K_STALL, 32'h0, "fetch_nostall");
    push(c + 1, K_RA, 32'h0, "read_r5_init");
    push(c + 1, K_RB, 32'h0, "read_r0_init");
    step(); wb(5, 32'hDEADBEEF);
    step(); fetch(5, 5);
    push(c + 1, K_RA, 32'hDEADBEEF, "read_r5_ra");
    push(c + 1, K_RB, 32'hDEADBEEF, "read_r5_rb");
    step(); wb(0, 32'h1234); fetch(0, 5); reg_rt_addr = 0;
    push(c, K_RT, 32'h0, "rt_r0_bypass_blocked");
    push(c + 1, K_RA, 32'h0, "ra_r0_bypass_blocked");
    push(c + 1, K_RB, 32'hDEADBEEF, "rb_r5_again");
    step(); fetch(0, 5); reg_rt_addr = 5;
    push(c, K_RT, 32'hDEADBEEF, "rt_r5");
    push(c + 1, K_RA, 32'h0, "ra_r0_stored");

    // Write-to-read bypass.
    step(); wb(7, 32'hA5A5A5A5); fetch(7, 7); reg_rt_addr = 7;
    push(c, K_RT, 32'hA5A5A5A5, "rt_bypass_r7");
    push(c, K_STALL, 32'h0, "bypass_nostall");
    push(c + 1, K_RA, 32'hA5A5A5A5, "ra_bypass_r7");
    push(c + 1, K_RB, 32'hA5A5A5A5, "rb_bypass_r7");

    // Link and writeback collide on r30: link wins.
    step(); do_link = 1; current_pc = 10'h3FF; wb(30, 32'h55); fetch(30, 7); reg_rt_addr = 30;
    push(c, K_RT, 32'h000003FF, "rt_link_bypass");
    push(c + 1, K_RA, 32'h000003FF, "ra_link_bypass");
    push(c + 1, K_RB, 32'hA5A5A5A5, "rb_r7_stored");
    step(); fetch(30, 30);
    push(c + 1, K_RA, 32'h000003FF, "ra_r30_link_won");
    push(c + 1, K_RB, 32'h000003FF, "rb_r30_link_won");

    // Scoreboard: issue r3, fetch stalls and outputs hold.
    step(); issue_valid = 1; issue_dest_addr = 3;
    for (int i = 0; i < 3; i++) begin
      step(); fetch(3, 7);
      push(c, K_STALL, 32'h1, "stall_r3_busy");
      push(c + 1, K_RA, 32'h000003FF, "ra_hold_stall");
      push(c + 1, K_RB, 32'h000003FF, "rb_hold_stall");
    end
    step(); fetch(3, 7); wb(3, 32'h77);
    push(c, K_STALL, 32'h0, "wb_resolves_stall");
    push(c + 1, K_RA, 32'h77, "ra_r3_wb_bypass");
    push(c + 1, K_RB, 32'hA5A5A5A5, "rb_r7_after_stall");
    step(); fetch(3, 3);
    push(c, K_STALL, 32'h0, "r3_busy_cleared");
    push(c + 1, K_RA, 32'h77, "ra_r3_stored");

    // Same-cycle issue and writeback on r4: busy stays set, data still written.
    step(); issue_valid = 1; issue_dest_addr = 4; wb(4, 32'h9);
    step(); fetch(4, 0); reg_rt_addr = 4;
    push(c, K_STALL, 32'h1, "race_set_wins");
    push(c, K_RT, 32'h9, "rt_r4_written");
    push(c + 1, K_RA, 32'h77, "ra_hold_race");
    step(); fetch(4, 0); wb(4, 32'hA);
    push(c, K_STALL, 32'h0, "r4_wb_resolves");
    push(c + 1, K_RA, 32'hA, "ra_r4_bypass");

    // Issue to r0 never marks it busy.
    step(); issue_valid = 1; issue_dest_addr = 0;
    step(); fetch(0, 7);
    push(c, K_STALL, 32'h0, "r0_never_busy");
    push(c + 1, K_RA, 32'h0, "ra_r0");
    push(c + 1, K_RB, 32'hA5A5A5A5, "rb_r7_prereset");

    // Mid-operation reset clears registers, outputs and busy bits.
    step(); issue_valid = 1; issue_dest_addr = 8; wb(8, 32'h11);
    step(); issue_valid = 1; issue_dest_addr = 9;
    step(); fetch(8, 9);
    push(c, K_STALL, 32'h1, "r8_r9_busy");
    push(c, K_RB, 32'hA5A5A5A5, "rb_before_reset");
    step(); fetch(8, 9);
    #2 reset = 1;
    push(c, K_RA, 32'h0, "ra_async_reset");
    push(c, K_RB, 32'h0, "rb_async_reset");
    push(c, K_STALL, 32'h0, "stall_cleared_reset");
    step(); reset = 0; fetch(8, 9); reg_rt_addr = 8;
    push(c, K_STALL, 32'h0, "no_stall_after_reset");
    push(c, K_RT, 32'h0, "rt_r8_reset");
    push(c + 1, K_RA, 32'h0, "ra_r8_reset");
    push(c + 1, K_RB, 32'h0, "rb_r9_reset");
    step();

    repeat (20) begin
      if (q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL %s: never checked, expected %h at cycle %0d", e.name, e.val, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
